// File: rtl/agh_led_seq_ctrl_if.sv
// Avalon-MM slave bundle for the LED sequencer register block.
// No waitrequest; reads have a fixed latency of one clock.
interface agh_led_seq_ctrl_if;
    logic [3:0]  avs_address;
    logic        avs_read;
    logic        avs_write;
    logic [31:0] avs_writedata;
    logic [31:0] avs_readdata;

    modport master (
        output avs_address, avs_read, avs_write, avs_writedata,
        input  avs_readdata
    );

    modport slave (
        input  avs_address, avs_read, avs_write, avs_writedata,
        output avs_readdata
    );
endinterface

// File: rtl/agh_led_seq_ctrl.sv
// LED controller: direct register or 8-step pattern sequencer, global PWM
// brightness, and a level interrupt when a one-shot sequence completes.
module agh_led_seq_ctrl #(
    parameter int TICK_DIV = 50000,   // clk cycles per base tick, >= 1
    parameter int PWM_W    = 8        // PWM counter / DUTY width
) (
    input  logic              clk,
    input  logic              rst,
    agh_led_seq_ctrl_if.slave avs,
    output logic [7:0]        led,
    output logic              irq
);
    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

    localparam logic [3:0] A_CTRL       = 4'h0;
    localparam logic [3:0] A_STATUS     = 4'h1;
    localparam logic [3:0] A_DIRECT     = 4'h2;
    localparam logic [3:0] A_DUTY       = 4'h3;
    localparam logic [3:0] A_STEP_TICKS = 4'h4;
    localparam logic [3:0] A_SEQ_LEN    = 4'h5;

    typedef enum logic [1:0] {IDLE, RUN, HOLD} state_t;

    state_t           state;
    logic             en, seq_en, loop, ie, done;
    logic [7:0]       direct;
    logic [PWM_W-1:0] duty;
    logic [15:0]      step_ticks;
    logic [2:0]       seq_len;
    logic [7:0]       pat [8];
    logic [2:0]       step;
    logic [TW-1:0]    tick_cnt;
    logic [15:0]      timer;
    logic [PWM_W-1:0] pwm_cnt;

    logic             wr_ctrl, seq_stop, tick, expiry, done_set, done_clr, pwm_on;
    logic [15:0]      load_val;
    logic [7:0]       src;
    logic [31:0]      rd_mux;
    logic             unused_wdata;

    assign unused_wdata = ^avs.avs_writedata[31:16];

    assign wr_ctrl  = avs.avs_write && (avs.avs_address == A_CTRL);
    assign seq_stop = wr_ctrl && !avs.avs_writedata[1];
    assign tick     = (state == RUN) && (tick_cnt == TICK_LAST);
    assign expiry   = tick && (timer == 16'd1);
    assign load_val = (step_ticks == 16'd0) ? 16'd1 : step_ticks;
    // A stop request in the completing cycle cancels the completion.
    assign done_set = expiry && (step >= seq_len) && !loop && !seq_stop;
    assign done_clr = avs.avs_write && (avs.avs_address == A_STATUS) && avs.avs_writedata[1];
    assign src      = (state == IDLE) ? direct : pat[step];
    assign pwm_on   = (duty == '1) || (pwm_cnt < duty);
    assign irq      = done & ie;

    // Sequencer FSM: step index, step timer and run/hold/idle state.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state <= IDLE;
            step  <= 3'd0;
            timer <= 16'd0;
        end else if (seq_stop) begin
            state <= IDLE;
            step  <= 3'd0;
        end else if (state == IDLE) begin
            if (wr_ctrl) begin
                state <= RUN;
                step  <= 3'd0;
                timer <= load_val;
            end
        end else if (tick) begin
            if (timer != 16'd1) begin
                timer <= timer - 16'd1;
            end else begin
                timer <= load_val;
                if (step < seq_len)
                    step <= step + 3'd1;
                else if (loop)
                    step <= 3'd0;
                else
                    state <= HOLD;
            end
        end
    end

    // Base tick divider: free-runs in RUN, parked at zero elsewhere so RUN entry starts a fresh period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else if (state != RUN || tick_cnt == TICK_LAST)
            tick_cnt <= '0;
        else
            tick_cnt <= tick_cnt + TW'(1);
    end

    // Register file writes; DONE is sticky with set taking priority over W1C.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            {ie, loop, seq_en, en} <= 4'd0;
            done       <= 1'b0;
            direct     <= 8'd0;
            duty       <= '0;
            step_ticks <= 16'd1;
            seq_len    <= 3'd0;
            // NOTE: the pattern array is small and software-visible, so it is reset like any other register.
            for (int i = 0; i < 8; i++) pat[i] <= 8'd0;
        end else begin
            done <= done_set | (done & ~done_clr);
            if (avs.avs_write) begin
                case (avs.avs_address)
                    A_CTRL:       {ie, loop, seq_en, en} <= avs.avs_writedata[3:0];
                    A_DIRECT:     direct     <= avs.avs_writedata[7:0];
                    A_DUTY:       duty       <= avs.avs_writedata[PWM_W-1:0];
                    A_STEP_TICKS: step_ticks <= avs.avs_writedata[15:0];
                    A_SEQ_LEN:    seq_len    <= avs.avs_writedata[2:0];
                    default: if (avs.avs_address[3]) pat[avs.avs_address[2:0]] <= avs.avs_writedata[7:0];
                endcase
            end
        end
    end

    // Read data mux; unmapped addresses read as zero.
    always_comb begin
        // NOTE: default first so no path through the case leaves rd_mux unassigned (no latch).
        rd_mux = 32'd0;
        case (avs.avs_address)
            A_CTRL:       rd_mux[3:0]       = {ie, loop, seq_en, en};
            A_STATUS:     rd_mux[10:0]      = {step, 6'd0, done, state == RUN};
            A_DIRECT:     rd_mux[7:0]       = direct;
            A_DUTY:       rd_mux[PWM_W-1:0] = duty;
            A_STEP_TICKS: rd_mux[15:0]      = step_ticks;
            A_SEQ_LEN:    rd_mux[2:0]       = seq_len;
            default: if (avs.avs_address[3]) rd_mux[7:0] = pat[avs.avs_address[2:0]];
        endcase
    end

    // Registered outputs: read data (held between reads), PWM counter and LED drive.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            avs.avs_readdata <= 32'd0;
            pwm_cnt          <= '0;
            led              <= 8'd0;
        end else begin
            if (avs.avs_read) avs.avs_readdata <= rd_mux;
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            led     <= en ? (src & {8{pwm_on}}) : 8'd0;
        end
    end
endmodule
